song_recorder: RTL
==================

# song_recorder

Writer side of the song memory. Captures the player's live note, from the keyboard or mic path, at the fixed note rate and writes it into one of four song slots in a dual-port song RAM. The written image has the same layout the song playback reader consumes: 250 entries per slot, one note per half-second, terminated by the song-finish marker. Sits beside the game controller and is driven by its menu selection and the note inputs.

## Interface
Parameters:
- NOTE_LENGTH, 50_000_000: clock cycles per recorded note.
- SLOT_DEPTH, 250: entries per song slot, terminator included.
- ADDR_BITS, 10: song RAM address width.

Ports:
- clk_in  input  1  system clock; one clock domain.
- rst_in  input  1  reset; asynchronous, active-high.
- rec_start  input  1  single-cycle pulse; begin recording.
- rec_stop  input  1  single-cycle pulse; end recording.
- slot_choice  input  2  target slot; latched on an accepted rec_start.
- note_in  input  7  live note code; 0 = rest.
- mem_we  output  1  song RAM write enable, one cycle per write.
- mem_addr  output  ADDR_BITS  song RAM write address.
- mem_din  output  8  song RAM write data, {1'b0, note}.
- recording  output  1  high in RECORD and TERMINATE.
- done  output  1  high in DONE.
- note_count  output  8  notes written in the current or last take, terminator excluded.

## Operation
- States: IDLE, RECORD, TERMINATE, DONE.
- IDLE or DONE, with rec_start:
  - go to RECORD; latch slot_choice.
  - mem_addr base = SLOT_DEPTH*slot_choice, with the product computed at ADDR_BITS width.
  - counter = NOTE_LENGTH-1; note_count = 0.
- IDLE or DONE, rec_stop alone: ignored.
- RECORD, tick (counter == NOTE_LENGTH-1):
  - register a write: mem_we=1, mem_din={1'b0, note_in sampled at this edge}, mem_addr=current address.
  - counter=0; address+1; note_count+1.
- RECORD, no tick: counter+1.
- note_in == 7'h7F is written as 7'h00, so the terminator value never appears mid-song.
- RECORD → TERMINATE on either:
  - rec_stop, or
  - the tick that writes entry SLOT_DEPTH-2 (slot full, last entry reserved for the terminator).
- rec_stop coinciding with a tick: the sample is written, then TERMINATE.
- rec_start during RECORD or TERMINATE: ignored.
- TERMINATE: next edge registers mem_we=1, mem_din=8'h7F, mem_addr=next free address; go to DONE.
- DONE: holds done=1 and note_count until the next rec_start. A new take overwrites the slot.
- Reset at any point, including mid-take: all state clears; no terminator is written; the slot contents are undefined.

## Timing
- Reset values: state IDLE, mem_we 0, mem_addr 0, mem_din 0, recording 0, done 0, note_count 0, counter 0.
- All outputs are registered; no combinational input-to-output path.
- rec_start at edge E0:
  - recording=1 after E0.
  - first tick at E1; first mem_we pulse in the cycle after E1.
  - subsequent writes every NOTE_LENGTH cycles.
- rec_stop at edge Es (no tick): TERMINATE after Es; terminator write pulse after Es+1; done=1 after Es+1.
- mem_we is never high for more than one consecutive cycle, except a tick write immediately followed by the terminator write.

## Configuration
- Macro RECORDER_SKIP_SILENCE_EN:
  - Defined: rest samples (note 0) before the first non-zero note of a take are not written. The counter still runs; note_count and address do not advance.
  - Undefined: every tick writes, including leading rests.

## Structure
- Shared package song_pkg holds:
  - SONG_FINISH (7'h7F), NOTE_REST (7'h00), SLOT_DEPTH, NOTE_LENGTH.
  - the recorder state enum.
  - the slot-base function (SLOT_DEPTH*slot).
- The game controller and playback reader import the same constants.
- One sub-module, note_tick: the NOTE_LENGTH counter with load-to-max on start and a tick output.

## Test plan
Benches use NOTE_LENGTH=4.
- Slot 2, note_in=7'd40 constant, rec_start, then rec_stop 10 cycles later:
  - writes of 8'h28 at addresses 500, 501, 502;
  - then 8'h7F at 503; done=1, note_count=3.
- rec_stop on the same edge as a tick: the sample is written at addr N, the terminator at N+1; no write is lost.
- Slot 0, no stop: 249 note writes at 0..248, terminator at 249, DONE.
- note_in=7'h7F during RECORD: stored as 8'h00; only the final entry is 8'h7F.
- rst_in asserted mid-take, between clock edges: outputs clear immediately; no further mem_we pulses.
- RECORDER_SKIP_SILENCE_EN defined, note_in 0,0,33:
  - the first write is 8'h21 at the slot base;
  - without the macro, 8'h00, 8'h00, 8'h21 are written.

Source files
------------

// File: rtl/song_pkg.sv
// ---------------------------------------------------------------------------
// song_pkg
// Constants and types shared by the song recorder, the game controller and
// the song playback reader, so all of them agree on the layout of a song slot.
//   SONG_FINISH  note code that terminates a song image
//   NOTE_REST    note code for silence
//   SLOT_DEPTH   entries per song slot, terminator included
//   NOTE_LENGTH  clock cycles per recorded note (half a second at 100 MHz)
//   rec_state_t  recorder state encoding
//   slot_base()  first RAM address of a given slot
// ---------------------------------------------------------------------------
package song_pkg;

    localparam logic [6:0] SONG_FINISH = 7'h7F;
    localparam logic [6:0] NOTE_REST   = 7'h00;
    localparam int         SLOT_DEPTH  = 250;
    localparam int         NOTE_LENGTH = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECORD,
        ST_TERMINATE,
        ST_DONE
    } rec_state_t;

    // Full 32-bit product; callers truncate to their address width, which
    // gives the same result as multiplying at that width.
    function automatic logic [31:0] slot_base(input logic [1:0] slot, input int depth);
        logic [31:0] depth_u;
        depth_u = 32'(depth);
        return depth_u * {30'd0, slot};
    endfunction

endpackage

// File: rtl/song_recorder_note_tick.sv
// ---------------------------------------------------------------------------
// note_tick
// Note-rate counter for the song recorder. Loading jumps straight to the
// terminal count so the first tick lands on the very next enabled edge; after
// that a tick is produced once every NOTE_LENGTH enabled cycles.
// Ports:
//   clk_in  system clock
//   rst_in  asynchronous active-high reset
//   load    preload the counter to NOTE_LENGTH-1
//   enable  let the counter run and qualify the tick
//   tick    high while enabled and the counter sits at NOTE_LENGTH-1
// ---------------------------------------------------------------------------
module note_tick #(
    parameter int NOTE_LENGTH = 50_000_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic load,
    input  logic enable,
    output logic tick
);

    localparam int CW = (NOTE_LENGTH > 1) ? $clog2(NOTE_LENGTH) : 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(NOTE_LENGTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = enable && (count_q == COUNT_MAX);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = COUNT_MAX;
        end else if (enable) begin
            // Wrap to zero on the tick so the next tick is NOTE_LENGTH cycles away.
            count_d = tick ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/song_recorder.sv
// ---------------------------------------------------------------------------
// song_recorder
// Writer side of the song memory. Samples the live note once per NOTE_LENGTH
// cycles and writes it into one of four song slots of the dual-port song RAM,
// then closes the take with the SONG_FINISH terminator so the playback reader
// sees a well-formed image.
// Ports:
//   clk_in       system clock (single domain)
//   rst_in       asynchronous active-high reset
//   rec_start    pulse: begin a take (ignored while a take is in progress)
//   rec_stop     pulse: end the take (ignored when not recording)
//   slot_choice  target slot, captured when a take starts
//   note_in      live note code, 0 = rest
//   mem_we       RAM write enable, one cycle per write
//   mem_addr     RAM write address
//   mem_din      RAM write data {1'b0, note}
//   recording    high while a take or its terminator write is pending
//   done         high once the terminator has been written
//   note_count   notes written in the current/last take, terminator excluded
// Configuration macro: RECORDER_SKIP_SILENCE_EN -- when defined, rests before
// the first real note of a take are not written.
// ---------------------------------------------------------------------------
module song_recorder
    import song_pkg::*;
#(
    parameter int NOTE_LENGTH = song_pkg::NOTE_LENGTH,
    parameter int SLOT_DEPTH  = song_pkg::SLOT_DEPTH,
    parameter int ADDR_BITS   = 10
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rec_start,
    input  logic                 rec_stop,
    input  logic [1:0]           slot_choice,
    input  logic [6:0]           note_in,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_din,
    output logic                 recording,
    output logic                 done,
    output logic [7:0]           note_count
);

    rec_state_t state_q, state_d;

    // Next free address in the slot being recorded.
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           note_count_q, note_count_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]           mem_din_q, mem_din_d;
    logic                 recording_q, recording_d;
    logic                 done_q, done_d;

    logic start_accept;
    logic tick;
    logic write_ok;
    logic [6:0] note_clean;

`ifdef RECORDER_SKIP_SILENCE_EN
    logic seen_note_q, seen_note_d;
`endif

    assign start_accept = rec_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    note_tick #(
        .NOTE_LENGTH (NOTE_LENGTH)
    ) u_note_tick (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .load   (start_accept),
        .enable (state_q == ST_RECORD),
        .tick   (tick)
    );

    // The terminator code must never appear mid-song, so it is stored as a rest.
    assign note_clean = (note_in == SONG_FINISH) ? NOTE_REST : note_in;

`ifdef RECORDER_SKIP_SILENCE_EN
    assign write_ok = seen_note_q || (note_in != NOTE_REST);
`else
    assign write_ok = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        note_count_d = note_count_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
`ifdef RECORDER_SKIP_SILENCE_EN
        seen_note_d  = seen_note_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (rec_start) begin
                    state_d      = ST_RECORD;
                    addr_d       = ADDR_BITS'(slot_base(slot_choice, SLOT_DEPTH));
                    note_count_d = 8'd0;
`ifdef RECORDER_SKIP_SILENCE_EN
                    seen_note_d  = 1'b0;
`endif
                end
            end

            ST_RECORD: begin
                if (tick && write_ok) begin
                    mem_we_d     = 1'b1;
                    mem_din_d    = {1'b0, note_clean};
                    mem_addr_d   = addr_q;
                    addr_d       = addr_q + ADDR_BITS'(1);
                    note_count_d = note_count_q + 8'd1;
`ifdef RECORDER_SKIP_SILENCE_EN
                    seen_note_d  = 1'b1;
`endif
                end
                // The last entry of a slot is reserved for the terminator.
                if (rec_stop || (tick && write_ok && (note_count_q == 8'(SLOT_DEPTH - 2)))) begin
                    state_d = ST_TERMINATE;
                end
            end

            ST_TERMINATE: begin
                mem_we_d   = 1'b1;
                mem_din_d  = {1'b0, SONG_FINISH};
                mem_addr_d = addr_q;
                state_d    = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they change on
        // the same edge as the state itself.
        recording_d = (state_d == ST_RECORD) || (state_d == ST_TERMINATE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            note_count_q <= 8'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= 8'd0;
            recording_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            note_count_q <= note_count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            recording_q  <= recording_d;
            done_q       <= done_d;
        end
    end

`ifdef RECORDER_SKIP_SILENCE_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            seen_note_q <= 1'b0;
        end else begin
            seen_note_q <= seen_note_d;
        end
    end
`endif

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign recording  = recording_q;
    assign done       = done_q;
    assign note_count = note_count_q;

endmodule
